// File: rtl/samcoupe_pkg.sv
// Shared types and constants for the SAM Coupe MiST core.
package samcoupe_pkg;

    // Width of an SDRAM byte address.
    localparam int RAM_AW    = 25;

    // Width of a floppy image byte count.
    localparam int FDD_LEN_W = 20;

    // Upload sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } upl_state_t;

endpackage

// File: rtl/ioctl_upload_fifo.sv
// Small byte FIFO that holds prefetched SDRAM data for the upload link.
// DEPTH must be a power of two (at least 2) so the indices wrap for free.
module upload_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_idx_reg;
    logic [AW-1:0]    rd_idx_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    // Flush wins over everything; overflow and underflow requests are dropped.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    // Head of the queue comes straight from the storage flops.
    assign dout    = mem_reg[rd_idx_reg];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_idx_reg] <= din;
        end
    end

    // Read/write indices and occupancy count.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_idx_reg <= wr_idx_reg + AW'(1);
            end
            if (do_pop) begin
                rd_idx_reg <= rd_idx_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ioctl_upload.sv
// Streams a region of SDRAM out to the ARM through the misc read port,
// prefetching into a small FIFO so the SPI side never waits on SDRAM.
// FIFO_DEPTH must be a power of two, minimum 2.
module ioctl_upload
    import samcoupe_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int LEN_W      = FDD_LEN_W
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RAM_AW-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [RAM_AW-1:0] misc_addr,
    output logic              misc_rd,
    input  logic [7:0]        misc_dout,
    input  logic              misc_ready,
    output logic [7:0]        upl_data,
    output logic              upl_valid,
    input  logic              upl_ack,
    output logic              busy,
    output logic              done
);

    upl_state_t        state_reg, state_next;
    logic [RAM_AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LEN_W-1:0]  remaining_reg, remaining_next;
    logic [LEN_W-1:0]  sent_reg, sent_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic              misc_rd_reg, misc_rd_next;
    logic [RAM_AW-1:0] misc_addr_reg, misc_addr_next;
    logic              done_reg, done_next;
    logic              busy_reg, busy_next;

    logic              fifo_push;
    logic              fifo_flush;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        fifo_dout;

    logic              pop_eff;
    logic              aborting;
    logic [LEN_W-1:0]  sent_inc;
    logic              drained;

    assign misc_rd   = misc_rd_reg;
    assign misc_addr = misc_addr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign upl_valid = !fifo_empty;
    assign upl_data  = fifo_dout;

    // A pop only counts while a byte is actually on offer.
    assign pop_eff  = upl_ack && !fifo_empty;
    assign aborting = abort && (state_reg != IDLE);
    assign sent_inc = sent_reg + LEN_W'(pop_eff);
    // Counting this cycle's pop lets done follow the final ack by one cycle.
    assign drained  = (sent_inc == len_reg);

    upload_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (pop_eff),
        .flush   (fifo_flush),
        .din     (misc_dout),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // State register plus all registered outputs and counters.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_ptr_reg    <= '0;
            remaining_reg <= '0;
            sent_reg      <= '0;
            len_reg       <= '0;
            misc_rd_reg   <= 1'b0;
            misc_addr_reg <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_ptr_reg    <= rd_ptr_next;
            remaining_reg <= remaining_next;
            sent_reg      <= sent_next;
            len_reg       <= len_next;
            misc_rd_reg   <= misc_rd_next;
            misc_addr_reg <= misc_addr_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
        end
    end

    // Next-state logic; abort from any active state returns to IDLE.
    always_comb begin
        state_next = state_reg;
        if (aborting) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && (length != '0)) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (remaining_reg != '0) begin
                        if (!fifo_full) begin
                            state_next = WAIT;
                        end
                    end else if (drained) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
                end
                WAIT: begin
                    if (misc_ready) begin
                        state_next = FETCH;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and output next values for each state.
    always_comb begin
        rd_ptr_next    = rd_ptr_reg;
        remaining_next = remaining_reg;
        sent_next      = sent_inc;
        len_next       = len_reg;
        misc_rd_next   = misc_rd_reg;
        misc_addr_next = misc_addr_reg;
        done_next      = 1'b0;
        busy_next      = (state_next != IDLE);
        fifo_push      = 1'b0;
        fifo_flush     = 1'b0;
        if (aborting) begin
            // Drop the outstanding read; any late misc_ready lands in IDLE and is ignored.
            misc_rd_next = 1'b0;
            fifo_flush   = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            rd_ptr_next    = base_addr;
                            remaining_next = length;
                            len_next       = length;
                            sent_next      = '0;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (remaining_reg != '0) begin
                        if (!fifo_full) begin
                            misc_rd_next   = 1'b1;
                            misc_addr_next = rd_ptr_reg;
                        end
                    end else if (drained) begin
                        done_next = 1'b1;
                    end
                end
                WAIT: begin
                    if (misc_ready) begin
                        fifo_push      = 1'b1;
                        rd_ptr_next    = rd_ptr_reg + RAM_AW'(1);
                        remaining_next = remaining_reg - LEN_W'(1);
                        misc_rd_next   = 1'b0;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        done_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_upload.sv
// Directed bench for ioctl_upload with a fixed-latency SDRAM model.
`timescale 1ns/1ps
module tb_ioctl_upload;

    logic        clk_sys    = 1'b0;
    logic        reset      = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic [24:0] base_addr  = '0;
    logic [19:0] length     = '0;
    logic [24:0] misc_addr;
    logic        misc_rd;
    logic [7:0]  misc_dout  = '0;
    logic        misc_ready = 1'b0;
    logic [7:0]  upl_data;
    logic        upl_valid;
    logic        upl_ack    = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // SDRAM model state and activity counters
    int          ram_lat    = 3;
    bit          pend       = 1'b0;
    int          pend_cnt   = 0;
    logic [24:0] pend_addr  = '0;
    int          hs_cnt     = 0;
    int          rd_cycles  = 0;
    int          done_cnt   = 0;
    int          addr_err   = 0;
    logic [24:0] addr_log[$];

    ioctl_upload dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .length     (length),
        .misc_addr  (misc_addr),
        .misc_rd    (misc_rd),
        .misc_dout  (misc_dout),
        .misc_ready (misc_ready),
        .upl_data   (upl_data),
        .upl_valid  (upl_valid),
        .upl_ack    (upl_ack),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] ram_byte(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // RAM model: a read seen on misc_rd is answered ram_lat cycles later,
    // whether or not the request is still pending by then.
    always @(negedge clk_sys) begin
        misc_ready = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (misc_rd && (misc_addr !== pend_addr)) addr_err++;
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    misc_ready = 1'b1;
                    misc_dout  = ram_byte(pend_addr);
                    pend       = 1'b0;
                    if (misc_rd) begin
                        hs_cnt++;
                        addr_log.push_back(pend_addr);
                    end
                end
            end else if (misc_rd) begin
                pend      = 1'b1;
                pend_cnt  = ram_lat;
                pend_addr = misc_addr;
            end
            if (misc_rd) rd_cycles++;
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input logic [24:0] b, input logic [19:0] l);
        @(negedge clk_sys);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(negedge clk_sys);
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        int n = 0;
        while (!upl_valid && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        ok = upl_valid;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s valid_timeout: upl_valid=%0b after %0d cycles, required 1", name, upl_valid, n);
        end
    endtask

    // Pops n bytes, checking each against the RAM contents at base+i,
    // and checks done timing around the final pop.
    task automatic consume(input string name, input logic [24:0] base, input int n, input int gap);
        bit          ok;
        logic [24:0] a;
        logic [7:0]  exp;
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk_sys);
            wait_valid(name, ok);
            if (!ok) return;
            a   = base + 25'(i);
            exp = ram_byte(a);
            checks++;
            if (upl_data !== exp) begin
                errors++;
                $display("FAIL %s data[%0d]: got %h required %h", name, i, upl_data, exp);
            end else begin
                $display("%s: byte %0d addr %h data %h", name, i, a, upl_data);
            end
            upl_ack = 1'b1;
            @(negedge clk_sys);
            upl_ack = 1'b0;
            checks++;
            if (done !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s done_after_ack[%0d]: got %0b required %0b", name, i, done, (i == n - 1));
            end
            if (i == n - 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done: got %0b required 0", name, busy);
                end
                @(negedge clk_sys);
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_width: got %0b required 0", name, done);
                end
            end
        end
    endtask

    task automatic check_addrs(input string name, input int q0, input logic [24:0] base, input int n);
        checks++;
        if (addr_log.size() - q0 != n) begin
            errors++;
            $display("FAIL %s handshakes: got %0d required %0d", name, addr_log.size() - q0, n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (addr_log[q0 + i] !== base + 25'(i)) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %h required %h", name, i, addr_log[q0 + i], base + 25'(i));
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({misc_rd, misc_addr, upl_valid, upl_data, busy, done} !== 37'd0) begin
            errors++;
            $display("FAIL %s: rd=%0b addr=%h valid=%0b data=%h busy=%0b done=%0b, required all 0",
                     name, misc_rd, misc_addr, upl_valid, upl_data, busy, done);
        end else begin
            $display("%s: outputs at reset values", name);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_basic;
        int q0 = addr_log.size();
        ram_lat = 3;
        do_start(25'h0050000, 20'd4);
        checks++;
        if (misc_rd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic cycle1: rd=%0b busy=%0b required rd=0 busy=1", misc_rd, busy);
        end
        @(negedge clk_sys);
        checks++;
        if (misc_rd !== 1'b1 || misc_addr !== 25'h0050000) begin
            errors++;
            $display("FAIL basic cycle2: rd=%0b addr=%h required rd=1 addr=0050000", misc_rd, misc_addr);
        end
        consume("basic", 25'h0050000, 4, 10);
        check_addrs("basic", q0, 25'h0050000, 4);
    endtask

    task automatic test_zero_len;
        int r0 = rd_cycles;
        do_start(25'h0001000, 20'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len cycle1: done=%0b busy=%0b required done=1 busy=0", done, busy);
        end else begin
            $display("zero_len: done in cycle 1");
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_len idle[%0d]: done=%0b busy=%0b required 0 0", i, done, busy);
            end
        end
        checks++;
        if (rd_cycles != r0) begin
            errors++;
            $display("FAIL zero_len reads: got %0d rd cycles required 0", rd_cycles - r0);
        end
    endtask

    task automatic test_stall;
        int q0 = addr_log.size();
        int r0;
        ram_lat = 3;
        do_start(25'h0001234, 20'd8);
        repeat (30) @(negedge clk_sys);
        r0 = rd_cycles;
        repeat (20) @(negedge clk_sys);
        checks++;
        if (addr_log.size() - q0 != 2 || rd_cycles != r0) begin
            errors++;
            $display("FAIL stall reads: got %0d handshakes %0d rd cycles required 2 and 0",
                     addr_log.size() - q0, rd_cycles - r0);
        end else begin
            $display("stall: 2 reads then idle while FIFO full");
        end
        checks++;
        if (upl_data !== ram_byte(25'h0001234) || upl_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall head: valid=%0b data=%h required 1 %h", upl_valid, upl_data, ram_byte(25'h0001234));
        end
        upl_ack = 1'b1;
        @(negedge clk_sys);
        upl_ack = 1'b0;
        checks++;
        if (misc_rd !== 1'b0) begin
            errors++;
            $display("FAIL stall rd_after_ack1: got %0b required 0", misc_rd);
        end
        @(negedge clk_sys);
        checks++;
        if (misc_rd !== 1'b1 || misc_addr !== 25'h0001236) begin
            errors++;
            $display("FAIL stall rd_after_ack2: rd=%0b addr=%h required 1 0001236", misc_rd, misc_addr);
        end
        consume("stall", 25'h0001235, 7, 0);
        check_addrs("stall", q0, 25'h0001234, 8);
    endtask

    task automatic test_wrap;
        int q0 = addr_log.size();
        ram_lat = 2;
        do_start(25'h1FFFFFE, 20'd3);
        consume("wrap", 25'h1FFFFFE, 3, 0);
        check_addrs("wrap", q0, 25'h1FFFFFE, 3);
    endtask

    task automatic test_abort;
        int q0 = addr_log.size();
        int d0 = done_cnt;
        int n  = 0;
        ram_lat = 5;
        do_start(25'h0000100, 20'd3);
        while (!misc_rd && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (misc_rd !== 1'b1) begin
            errors++;
            $display("FAIL abort rd_timeout: rd=%0b required 1", misc_rd);
        end
        repeat (3) @(negedge clk_sys);
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        checks++;
        if (misc_rd !== 1'b0 || busy !== 1'b0 || upl_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort next_cycle: rd=%0b busy=%0b valid=%0b required 0 0 0", misc_rd, busy, upl_valid);
        end
        repeat (5) @(negedge clk_sys);
        checks++;
        if (upl_valid !== 1'b0 || done_cnt != d0 || addr_log.size() != q0) begin
            errors++;
            $display("FAIL abort late_data: valid=%0b dones=%0d handshakes=%0d required 0 0 0",
                     upl_valid, done_cnt - d0, addr_log.size() - q0);
        end else begin
            $display("abort: late data dropped, no done");
        end
        ram_lat = 3;
        do_start(25'h0000300, 20'd2);
        consume("after_abort", 25'h0000300, 2, 2);
    endtask

    task automatic test_reset_mid;
        int q0 = addr_log.size();
        int d0;
        int n  = 0;
        ram_lat = 1;
        do_start(25'h0007000, 20'd2);
        while (addr_log.size() - q0 < 2 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (3) @(negedge clk_sys);
        checks++;
        if (upl_data !== ram_byte(25'h0007000)) begin
            errors++;
            $display("FAIL reset_mid head: got %h required %h", upl_data, ram_byte(25'h0007000));
        end
        upl_ack = 1'b1;
        @(negedge clk_sys);
        upl_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (upl_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid drain: valid=%0b busy=%0b required 1 1", upl_valid, busy);
        end
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_mid async");
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || upl_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after: dones=%0d busy=%0b valid=%0b required 0 0 0", done_cnt - d0, busy, upl_valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_len;
        test_stall;
        test_wrap;
        test_abort;
        test_reset_mid;
        checks++;
        if (addr_err != 0) begin
            errors++;
            $display("FAIL addr_stable: %0d cycles with misc_addr changing during a read, required 0", addr_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
